char_string_renderer: RTL and testbench
=======================================

# char_string_renderer

Parametrised text renderer for the 160x120, 6-bit-colour frame buffer path. It latches a short string of character codes plus an origin, then walks an internal glyph ROM pixel by pixel. For every lit pixel it emits one plot request (x, y, colour) under a valid/ready handshake toward the VGA plot arbiter. It generalises the per-letter glyph LUTs into one sequential block covering a full character set and a configurable string length.

## Interface
- NUM_CHARS, 8, characters per string (1..16)
- GLYPH_W, 8, glyph cell width in pixels (power of two)
- GLYPH_H, 10, glyph cell height in pixels
- clock  input  1  system clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  request a render; sampled only in IDLE
- origin_x  input  8  x of top-left of character 0
- origin_y  input  8  y of top-left of the string
- colour  input  6  foreground colour
- bg_colour  input  6  background colour (used only with CHAR_BG_FILL_EN)
- text  input  6*NUM_CHARS  character codes; char i in bits [6i+5:6i]
- plot_ready  input  1  arbiter accepts the current plot
- plot  output  1  plot request valid
- plot_x  output  8  pixel x
- plot_y  output  8  pixel y
- plot_colour  output  6  pixel colour
- busy  output  1  render in progress
- done  output  1  one-cycle completion pulse

## Operation
- Code map: 0 = space (blank); 1..26 = A..Z; 27..36 = digits 0..9; 37..63 render blank.
- Glyph 'H' (code 8) is fixed: columns 2 and 7 lit on rows 0..9; row 5 also lit on columns 2..7. All other glyphs fit columns 1..GLYPH_W-1 and rows 0..GLYPH_H-1.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE: start=1 latches origin_x, origin_y, colour, bg_colour and text, clears the cursor (char=0, row=0, col=0), and moves to SCAN.
- SCAN: the glyph bit at the cursor is looked up combinationally.
  - Pixel lit: register plot_x = origin_x + char*GLYPH_W + col and plot_y = origin_y + row, both mod 256, then go to EMIT.
  - Pixel unlit: advance the cursor and stay in SCAN, or go to DONE if this was the last pixel.
- EMIT: plot is held at 1 with plot_x, plot_y and plot_colour stable until plot_ready=1.
  - That cycle completes the transfer. plot drops, the cursor advances, and the state becomes SCAN, or DONE after the last pixel.
- Cursor order: col fastest, then row, then char.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored outside IDLE. Latched inputs are immune to input changes mid-render.
- Coordinates wrap modulo 256. No clipping to 160x120 is done here; that is the arbiter's job.

## Timing
- Reset: state IDLE; plot, plot_x, plot_y, plot_colour, busy and done are all 0. Asserting reset mid-render aborts it immediately; no further plots are issued.
- busy rises the cycle after start is sampled and stays high through SCAN and EMIT. busy is low in DONE and IDLE.
- An unlit pixel costs 1 cycle. A lit pixel costs 1 SCAN cycle plus at least 1 EMIT cycle (more while plot_ready=0).
- Minimum total: NUM_CHARS*GLYPH_W*GLYPH_H + (lit pixel count) cycles from start to done.
- plot_ready arriving while plot=0 has no effect.
- The transfer completes on any cycle where plot=1 and plot_ready=1. There is no combinational path from plot_ready to plot.

## Configuration
- CHAR_BG_FILL_EN defined: unlit pixels are also emitted, with plot_colour=bg_colour. Every render issues exactly NUM_CHARS*GLYPH_W*GLYPH_H plots.
- CHAR_BG_FILL_EN undefined: unlit pixels are skipped (transparent) and bg_colour is ignored.

## Test plan
- Reset check: assert resetn=0 mid-render -> plot=0, busy=0, done=0 within the same cycle; no plot after release until a new start.
- Render 'H': NUM_CHARS=1, text=8, origin (10,20), colour=6'h3F, plot_ready=1 -> exactly 24 plots.
  - First plot is (12,20), last is (17,29), all with colour 6'h3F.
  - Row 5 gives x=12..17 in order.
  - done pulses once.
- All spaces: NUM_CHARS=8, all codes 0 -> zero plots; done after 640 SCAN cycles; busy high throughout.
- Backpressure: on the first 'H' plot, hold plot_ready=0 for 5 cycles -> plot=1 and (12,20) stay stable for 5 cycles, then advance; still 24 plots total.
- Wrap and ignored start: origin_x=250, text 'H' -> column 7 plots at x=1. A start pulse during busy -> no second render.
- With CHAR_BG_FILL_EN: single space, bg_colour=6'h05 -> 80 plots, all colour 6'h05, covering (ox..ox+7, oy..oy+9).

Source files
------------

// File: rtl/char_string_renderer.sv
// char_string_renderer
// Latches a string of 6-bit character codes plus an origin, walks the glyph ROM
// pixel by pixel (col fastest, then row, then char) and issues one plot request
// per emitted pixel under a valid/ready handshake.
// Optional build macro: CHAR_BG_FILL_EN -- also emit unlit pixels in bg_colour.
module char_string_renderer #(
    parameter int NUM_CHARS = 8,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 10
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [7:0]             origin_x,
    input  logic [7:0]             origin_y,
    input  logic [5:0]             colour,
    input  logic [5:0]             bg_colour,
    input  logic [6*NUM_CHARS-1:0] text,
    input  logic                   plot_ready,
    output logic                   plot,
    output logic [7:0]             plot_x,
    output logic [7:0]             plot_y,
    output logic [5:0]             plot_colour,
    output logic                   busy,
    output logic                   done
);

    localparam int CHAR_BITS = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int COL_BITS  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_BITS  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

`ifdef CHAR_BG_FILL_EN
    localparam logic BG_FILL = 1'b1;
`else
    localparam logic BG_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT, ST_DONE} state_t;

    // Glyph ROM: 8x10 cells, row 0 in the top byte, bit c of a row = column c.
    // Every glyph occupies columns 2..7 so column 0 and 1 stay as spacing.
    function automatic logic [7:0] glyph_row(input logic [5:0] code, input logic [3:0] row);
        logic [79:0] g;
        logic [7:0]  r;
        case (code)
            6'd1:  g = 80'h30_48_84_84_84_FC_84_84_84_84; // A
            6'd2:  g = 80'h7C_84_84_84_7C_84_84_84_84_7C; // B
            6'd3:  g = 80'h78_84_04_04_04_04_04_04_84_78; // C
            6'd4:  g = 80'h3C_44_84_84_84_84_84_84_44_3C; // D
            6'd5:  g = 80'hFC_04_04_04_7C_04_04_04_04_FC; // E
            6'd6:  g = 80'hFC_04_04_04_7C_04_04_04_04_04; // F
            6'd7:  g = 80'h78_84_04_04_04_E4_84_84_84_78; // G
            6'd8:  g = 80'h84_84_84_84_84_FC_84_84_84_84; // H
            6'd9:  g = 80'h78_30_30_30_30_30_30_30_30_78; // I
            6'd10: g = 80'hF0_40_40_40_40_40_40_44_44_38; // J
            6'd11: g = 80'h84_44_24_14_0C_0C_14_24_44_84; // K
            6'd12: g = 80'h04_04_04_04_04_04_04_04_04_FC; // L
            6'd13: g = 80'h84_CC_B4_B4_84_84_84_84_84_84; // M
            6'd14: g = 80'h84_8C_8C_94_94_A4_A4_C4_C4_84; // N
            6'd15: g = 80'h78_84_84_84_84_84_84_84_84_78; // O
            6'd16: g = 80'h7C_84_84_84_7C_04_04_04_04_04; // P
            6'd17: g = 80'h78_84_84_84_84_84_A4_C4_78_80; // Q
            6'd18: g = 80'h7C_84_84_84_7C_14_24_44_84_84; // R
            6'd19: g = 80'h78_84_04_04_78_80_80_80_84_78; // S
            6'd20: g = 80'hFC_30_30_30_30_30_30_30_30_30; // T
            6'd21: g = 80'h84_84_84_84_84_84_84_84_84_78; // U
            6'd22: g = 80'h84_84_84_84_84_48_48_48_30_30; // V
            6'd23: g = 80'h84_84_84_84_84_B4_B4_B4_CC_84; // W
            6'd24: g = 80'h84_84_48_48_30_30_48_48_84_84; // X
            6'd25: g = 80'h84_84_48_48_30_30_30_30_30_30; // Y
            6'd26: g = 80'hFC_80_40_40_20_10_08_08_04_FC; // Z
            6'd27: g = 80'h78_84_C4_C4_A4_94_8C_8C_84_78; // 0
            6'd28: g = 80'h30_38_34_30_30_30_30_30_30_FC; // 1
            6'd29: g = 80'h78_84_80_80_40_20_10_08_04_FC; // 2
            6'd30: g = 80'h78_84_80_80_70_80_80_80_84_78; // 3
            6'd31: g = 80'h40_60_50_48_44_FC_40_40_40_40; // 4
            6'd32: g = 80'hFC_04_04_7C_80_80_80_80_84_78; // 5
            6'd33: g = 80'h78_04_04_7C_84_84_84_84_84_78; // 6
            6'd34: g = 80'hFC_80_40_40_20_20_10_10_10_10; // 7
            6'd35: g = 80'h78_84_84_84_78_84_84_84_84_78; // 8
            6'd36: g = 80'h78_84_84_84_84_F8_80_80_40_3C; // 9
            default: g = 80'h0;                           // space and unused codes
        endcase
        if (row <= 4'd9) begin
            r = g[79 - 8*row -: 8];
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    state_t                   state_r;
    logic [7:0]               origin_x_r, origin_y_r;
    logic [5:0]               colour_r, bg_r;
    logic [6*NUM_CHARS-1:0]   text_r;
    logic [CHAR_BITS-1:0]     char_r, nxt_char_s;
    logic [ROW_BITS-1:0]      row_r, nxt_row_s;
    logic [COL_BITS-1:0]      col_r, nxt_col_s;

    logic [5:0]  code_s;
    logic [31:0] row_ext_s, col_ext_s;
    logic [7:0]  row_bits_s;
    logic        pixel_s, emit_s, last_s;
    logic [7:0]  plot_x_s, plot_y_s;
    logic [5:0]  colour_s;

    // Glyph lookup at the cursor, pixel coordinates and the next cursor position
    always_comb begin
        code_s     = text_r[6*char_r +: 6];
        row_ext_s  = 32'(row_r);
        col_ext_s  = 32'(col_r);
        row_bits_s = glyph_row(code_s, row_ext_s[3:0]);
        if ((row_ext_s < 32'd10) && (col_ext_s < 32'd8)) begin
            pixel_s = row_bits_s[col_ext_s[2:0]];
        end else begin
            pixel_s = 1'b0;
        end
        emit_s   = pixel_s | BG_FILL;
        colour_s = pixel_s ? colour_r : bg_r;
        plot_x_s = origin_x_r + 8'(32'(char_r) * GLYPH_W + 32'(col_r));
        plot_y_s = origin_y_r + 8'(row_r);

        nxt_char_s = char_r;
        nxt_row_s  = row_r;
        nxt_col_s  = col_r + COL_BITS'(1);
        if (col_r == COL_BITS'(GLYPH_W - 1)) begin
            nxt_col_s = '0;
            if (row_r == ROW_BITS'(GLYPH_H - 1)) begin
                nxt_row_s  = '0;
                nxt_char_s = char_r + CHAR_BITS'(1);
            end else begin
                nxt_row_s = row_r + ROW_BITS'(1);
            end
        end else begin
            nxt_col_s = col_r + COL_BITS'(1);
        end
        last_s = (char_r == CHAR_BITS'(NUM_CHARS - 1)) &&
                 (row_r == ROW_BITS'(GLYPH_H - 1)) &&
                 (col_r == COL_BITS'(GLYPH_W - 1));
    end

    // Render FSM with latched inputs, cursor and registered handshake outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            origin_x_r  <= 8'd0;
            origin_y_r  <= 8'd0;
            colour_r    <= 6'd0;
            bg_r        <= 6'd0;
            text_r      <= '0;
            char_r      <= '0;
            row_r       <= '0;
            col_r       <= '0;
            plot        <= 1'b0;
            plot_x      <= 8'd0;
            plot_y      <= 8'd0;
            plot_colour <= 6'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        origin_x_r <= origin_x;
                        origin_y_r <= origin_y;
                        colour_r   <= colour;
                        bg_r       <= bg_colour;
                        text_r     <= text;
                        char_r     <= '0;
                        row_r      <= '0;
                        col_r      <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (emit_s) begin
                        plot        <= 1'b1;
                        plot_x      <= plot_x_s;
                        plot_y      <= plot_y_s;
                        plot_colour <= colour_s;
                        state_r     <= ST_EMIT;
                    end else if (last_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        char_r <= nxt_char_s;
                        row_r  <= nxt_row_s;
                        col_r  <= nxt_col_s;
                    end
                end
                ST_EMIT: begin
                    // plot/x/y/colour hold until the arbiter takes the pixel
                    if (plot_ready) begin
                        plot <= 1'b0;
                        if (last_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            char_r  <= nxt_char_s;
                            row_r   <= nxt_row_s;
                            col_r   <= nxt_col_s;
                            state_r <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_string_renderer.sv
// Self-checking bench for char_string_renderer (NUM_CHARS=8, 8x10 cells).
// Expected plots come from a reference model using only glyphs fully defined
// by the character map: space, 'H' and the blank codes 37..63.
module tb_char_string_renderer;

    localparam int NC    = 8;
    localparam int CELLS = NC * 8 * 10;
`ifdef CHAR_BG_FILL_EN
    localparam bit BG = 1'b1;
`else
    localparam bit BG = 1'b0;
`endif

    logic          clock, resetn, start;
    logic [7:0]    origin_x, origin_y;
    logic [5:0]    colour, bg_colour;
    logic [6*NC-1:0] text;
    logic          plot_ready;
    logic          plot;
    logic [7:0]    plot_x, plot_y;
    logic [5:0]    plot_colour;
    logic          busy, done;

    char_string_renderer #(.NUM_CHARS(NC), .GLYPH_W(8), .GLYPH_H(10)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .origin_x(origin_x), .origin_y(origin_y),
        .colour(colour), .bg_colour(bg_colour), .text(text),
        .plot_ready(plot_ready), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [21:0] exp_q[$];
    logic [21:0] cap_q[$];
    int done_cnt = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [47:0] t;
        logic [7:0]  ox, oy;
        logic [5:0]  c;
        int          n;
        int          fx, fy, lx, ly;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Capture accepted plots, done pulses and busy cycles away from the active edge
    always @(negedge clock) begin
        if (resetn) begin
            if (plot && plot_ready) cap_q.push_back({plot_x, plot_y, plot_colour});
            if (done) done_cnt = done_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
        end
    end

    function automatic bit ref_lit(input int code, input int r, input int c);
        if (code == 8) return (c == 2) || (c == 7) || (r == 5 && c >= 2 && c <= 7);
        return 1'b0; // space and codes 37..63 are blank
    endfunction

    // Reference: scan every cell pixel in col/row/char order, emit lit (or all with fill)
    function automatic void build_exp(input logic [47:0] t, input int ox, input int oy,
                                      input logic [5:0] c, input logic [5:0] bg);
        exp_q.delete();
        for (int ch = 0; ch < NC; ch++)
            for (int r = 0; r < 10; r++)
                for (int cl = 0; cl < 8; cl++) begin
                    int  code;
                    bit  lit;
                    int  xi, yi;
                    code = int'(t[6*ch +: 6]);
                    lit  = ref_lit(code, r, cl);
                    xi   = (ox + ch * 8 + cl) % 256;
                    yi   = (oy + r) % 256;
                    if (lit || BG) exp_q.push_back({8'(xi), 8'(yi), lit ? c : bg});
                end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall first plot 5 cycles, 3: start pulse mid-render
    task automatic run_render(input logic [47:0] t, input logic [7:0] ox, input logic [7:0] oy,
                              input logic [5:0] c, input logic [5:0] bg, input int mode);
        bit fin;
        int stall;
        build_exp(t, int'(ox), int'(oy), c, bg);
        cap_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        fin = 1'b0;
        stall = 0;
        text = t; origin_x = ox; origin_y = oy; colour = c; bg_colour = bg;
        start = 1'b1;
        plot_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8000 && !fin; i++) begin
            case (mode)
                1: plot_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (plot && stall < 5) begin
                        chk("stall_x", int'(plot_x), int'(exp_q[0][21:14]));
                        chk("stall_y", int'(plot_y), int'(exp_q[0][13:6]));
                        plot_ready = 1'b0;
                        stall++;
                    end else begin
                        plot_ready = 1'b1;
                    end
                end
                3: begin
                    plot_ready = 1'b1;
                    if (i == 40) begin
                        start = 1'b1;
                        origin_x = ox + 8'd33;
                        origin_y = oy + 8'd7;
                        text = ~t;
                    end else begin
                        start = 1'b0;
                    end
                end
                default: plot_ready = 1'b1;
            endcase
            tick();
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", int'(fin), 1);
        repeat (5) tick();
        chk("done_once", done_cnt, 1);
        if (mode == 2) chk("stall_cycles", stall, 5);
        if (mode == 0) chk("busy_cycles", busy_cnt, CELLS + exp_q.size());
        chk("plot_count", cap_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
            chk($sformatf("plot[%0d]", k), int'(cap_q[k]), int'(exp_q[k]));
    endtask

    initial begin
        clock = 1'b0; resetn = 1'b0; start = 1'b0;
        origin_x = 8'd0; origin_y = 8'd0; colour = 6'd0; bg_colour = 6'd0;
        text = '0; plot_ready = 1'b0;

        vecs[0] = '{48'd8,             8'd10,  8'd20,  6'h3F, 24, 12,  20,  17,  29};
        vecs[1] = '{48'd0,             8'd5,   8'd7,   6'h2A, 0,  0,   0,   0,   0};
        vecs[2] = '{48'd8 << 18,       8'd0,   8'd0,   6'h11, 24, 26,  0,   31,  9};
        vecs[3] = '{(48'd8 << 42) | 48'd8, 8'd100, 8'd100, 6'h01, 48, 102, 100, 163, 109};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 8'd3,  8'd4,   6'h15, 0,  0,   0,   0,   0};

        // reset state
        repeat (2) tick();
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(plot_x), 0);
        chk("rst_y", int'(plot_y), 0);
        chk("rst_colour", int'(plot_colour), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // table-driven renders at full rate
        foreach (vecs[v]) begin
            int n, fx, fy, lx, ly;
            if (BG) begin
                n = CELLS; fx = int'(vecs[v].ox); fy = int'(vecs[v].oy);
                lx = (int'(vecs[v].ox) + 63) % 256; ly = (int'(vecs[v].oy) + 9) % 256;
            end else begin
                n = vecs[v].n; fx = vecs[v].fx; fy = vecs[v].fy; lx = vecs[v].lx; ly = vecs[v].ly;
            end
            run_render(vecs[v].t, vecs[v].ox, vecs[v].oy, vecs[v].c, 6'h05, 0);
            chk($sformatf("vec%0d_count", v), cap_q.size(), n);
            if (n > 0 && cap_q.size() > 0) begin
                chk($sformatf("vec%0d_first_x", v), int'(cap_q[0][21:14]), fx);
                chk($sformatf("vec%0d_first_y", v), int'(cap_q[0][13:6]), fy);
                chk($sformatf("vec%0d_last_x", v), int'(cap_q[cap_q.size()-1][21:14]), lx);
                chk($sformatf("vec%0d_last_y", v), int'(cap_q[cap_q.size()-1][13:6]), ly);
            end
        end

        // backpressure on the first plot of 'H'
        run_render(48'd8, 8'd10, 8'd20, 6'h3F, 6'h05, 2);
        // wrap at x=250 plus ignored start pulse with changed inputs mid-render
        run_render(48'd8, 8'd250, 8'd20, 6'h2C, 6'h05, 3);

        // randomized strings, origins and ready pattern against the model
        for (int it = 0; it < 8; it++) begin
            logic [47:0] t;
            for (int ch = 0; ch < NC; ch++) begin
                int sel;
                sel = $urandom_range(0, 2);
                t[6*ch +: 6] = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd8 : 6'($urandom_range(37, 63));
            end
            run_render(t, 8'($urandom), 8'($urandom), 6'($urandom), 6'($urandom), 1);
        end

        // reset mid-render while a plot is pending
        text = 48'd8; origin_x = 8'd10; origin_y = 8'd20; colour = 6'h3F;
        plot_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !plot; i++) tick();
        chk("pre_reset_plot", int'(plot), 1);
        resetn = 1'b0;
        #1;
        chk("mid_reset_plot", int'(plot), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_done", int'(done), 0);
        tick();
        @(negedge clock);
        resetn = 1'b1;
        cap_q.delete();
        done_cnt = 0;
        plot_ready = 1'b1;
        repeat (700) tick();
        chk("post_reset_plots", cap_q.size(), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
